// File: rtl/alarm_unit.sv
// Alarm stage: compares the timer's hour/minute with a CPU-programmed alarm time and
// drives a beep square wave until stop, timeout or disable. Snooze support: ALARM_SNOOZE_EN.
module alarm_unit #(
    parameter int BEEP_HALF   = 5000,
    parameter int RING_CYCLES = 600000000,
    parameter int SNOOZE_MIN  = 5
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        w_en_n,
    input  logic [7:0]  t,
    input  logic [15:0] addr,
    input  logic [5:0]  hour,
    input  logic [5:0]  minute,
    input  logic        stop_n,
    input  logic        snooze_n,
    output logic        beep,
    output logic        ringing,
    output logic        snoozing
);
    localparam int RING_W = (RING_CYCLES > 1) ? $clog2(RING_CYCLES) : 1;
    localparam int BEEP_W = (BEEP_HALF > 1) ? $clog2(BEEP_HALF) : 1;
    localparam logic [RING_W-1:0] RING_LAST = RING_W'(RING_CYCLES - 1);
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_HALF - 1);

`ifdef ALARM_SNOOZE_EN
    typedef enum logic [1:0] {ST_IDLE, ST_RINGING, ST_SNOOZE} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_RINGING} state_t;
`endif

    state_t            state_reg;
    logic [5:0]        alarm_hour_reg;
    logic [5:0]        alarm_min_reg;
    logic              alarm_en_reg;
    logic              match_q_reg;
    logic              stop_q_reg;
    logic [RING_W-1:0] ring_cnt_reg;
    logic [BEEP_W-1:0] beep_cnt_reg;

    logic match;
    logic trigger;
    logic stop_ev;

    // Upper address bits belong to the system decoder; snooze_n is idle without snooze support.
    logic unused_inputs;
    assign unused_inputs = &{1'b0, addr[15:4], snooze_n};

    assign match   = alarm_en_reg && (hour == alarm_hour_reg) && (minute == alarm_min_reg);
    assign trigger = match && !match_q_reg;
    assign stop_ev = stop_q_reg && !stop_n;

`ifdef ALARM_SNOOZE_EN
    logic [5:0] prev_minute_reg;
    logic       snooze_q_reg;
    logic [3:0] snooze_cnt_reg;
    logic       minute_tick;
    logic       snooze_ev;

    assign minute_tick = (minute != prev_minute_reg);
    assign snooze_ev   = snooze_q_reg && !snooze_n;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            prev_minute_reg <= '0;
            snooze_q_reg    <= 1'b1;
        end else begin
            prev_minute_reg <= minute;
            snooze_q_reg    <= snooze_n;
        end
    end
`else
    assign snoozing = 1'b0;
`endif

    // CPU register file; out-of-range times are dropped rather than clipped.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            alarm_hour_reg <= '0;
            alarm_min_reg  <= '0;
            alarm_en_reg   <= 1'b0;
            match_q_reg    <= 1'b0;
            stop_q_reg     <= 1'b1;
        end else begin
            if (!w_en_n) begin
                case (addr[3:0])
                    4'b1010: if (t <= 8'd23) alarm_hour_reg <= t[5:0];
                    4'b1011: if (t <= 8'd59) alarm_min_reg <= t[5:0];
                    4'b1100: alarm_en_reg <= t[0];
                    default: ;
                endcase
            end
            match_q_reg <= match;
            stop_q_reg  <= stop_n;
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ring_cnt_reg <= '0;
            beep_cnt_reg <= '0;
            beep         <= 1'b0;
            ringing      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_reg <= '0;
            snoozing       <= 1'b0;
`endif
        end else begin
            ringing <= (state_reg == ST_RINGING);
`ifdef ALARM_SNOOZE_EN
            snoozing <= (state_reg == ST_SNOOZE);
`endif
            if (!alarm_en_reg) begin
                state_reg <= ST_IDLE;
                beep      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (trigger) begin
                            state_reg    <= ST_RINGING;
                            ring_cnt_reg <= '0;
                            beep_cnt_reg <= '0;
                            beep         <= 1'b1;
                        end
                    end
                    ST_RINGING: begin
                        if (stop_ev) begin
                            state_reg <= ST_IDLE;
                            beep      <= 1'b0;
`ifdef ALARM_SNOOZE_EN
                        end else if (snooze_ev) begin
                            state_reg      <= ST_SNOOZE;
                            snooze_cnt_reg <= 4'(SNOOZE_MIN);
                            beep           <= 1'b0;
`endif
                        end else if (ring_cnt_reg == RING_LAST) begin
                            state_reg <= ST_IDLE;
                            beep      <= 1'b0;
                        end else begin
                            ring_cnt_reg <= ring_cnt_reg + RING_W'(1);
                            if (beep_cnt_reg == BEEP_LAST) begin
                                beep_cnt_reg <= '0;
                                beep         <= ~beep;
                            end else begin
                                beep_cnt_reg <= beep_cnt_reg + BEEP_W'(1);
                            end
                        end
                    end
`ifdef ALARM_SNOOZE_EN
                    ST_SNOOZE: begin
                        if (stop_ev) begin
                            state_reg <= ST_IDLE;
                        end else if (minute_tick) begin
                            if (snooze_cnt_reg == 4'd1) begin
                                state_reg    <= ST_RINGING;
                                ring_cnt_reg <= '0;
                                beep_cnt_reg <= '0;
                                beep         <= 1'b1;
                            end else begin
                                snooze_cnt_reg <= snooze_cnt_reg - 4'd1;
                            end
                        end
                    end
`endif
                    default: begin
                        state_reg <= ST_IDLE;
                        beep      <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_alarm_unit.sv
// Bench for alarm_unit: register-write vector table, hand sequences for latency/timeout/
// button/reset corners, and randomized traffic against a time-based reference model.
module tb_alarm_unit;
    localparam int BEEP_HALF   = 4;
    localparam int RING_CYCLES = 100;
    localparam int SNOOZE_MIN  = 2;

    logic        clock = 1'b0;
    logic        rst_n = 1'b0;
    logic        w_en_n = 1'b1;
    logic [7:0]  t = 8'd0;
    logic [15:0] addr = 16'd0;
    logic [5:0]  hour = 6'd0;
    logic [5:0]  minute = 6'd0;
    logic        stop_n = 1'b1;
    logic        snooze_n = 1'b1;
    logic        beep;
    logic        ringing;
    logic        snoozing;

    int checks = 0;
    int errors = 0;

    alarm_unit #(
        .BEEP_HALF(BEEP_HALF),
        .RING_CYCLES(RING_CYCLES),
        .SNOOZE_MIN(SNOOZE_MIN)
    ) dut (
        .clock(clock),
        .rst_n(rst_n),
        .w_en_n(w_en_n),
        .t(t),
        .addr(addr),
        .hour(hour),
        .minute(minute),
        .stop_n(stop_n),
        .snooze_n(snooze_n),
        .beep(beep),
        .ringing(ringing),
        .snoozing(snoozing)
    );

    always #5 clock = ~clock;

    function automatic void check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: ringing is tracked as the edge index it started on, so beep phase
    // and timeout come straight from elapsed time.
    localparam int M_IDLE = 0, M_RING = 1, M_SNZ = 2;
    int m_state = M_IDLE, m_start = 0, m_left = 0, m_edge = 0;
    int m_ah = 0, m_am = 0, m_prev = 0;
    bit m_en = 0, m_match_q = 0, m_stop_q = 1, m_snz_q = 1;
    bit m_ringing = 0, m_snoozing = 0, m_beep = 0;

    always @(posedge clock or negedge rst_n) begin
        bit match, trig, tick_ev, stop_ev, snz_ev;
        if (!rst_n) begin
            m_state = M_IDLE; m_ah = 0; m_am = 0; m_en = 0; m_match_q = 0; m_prev = 0;
            m_stop_q = 1; m_snz_q = 1; m_ringing = 0; m_snoozing = 0; m_beep = 0;
        end else begin
            match   = m_en && (int'(hour) == m_ah) && (int'(minute) == m_am);
            trig    = match && !m_match_q;
            tick_ev = int'(minute) != m_prev;
            stop_ev = m_stop_q && !stop_n;
`ifdef ALARM_SNOOZE_EN
            snz_ev  = m_snz_q && !snooze_n;
`else
            snz_ev  = 1'b0;
`endif
            m_ringing  = (m_state == M_RING);
            m_snoozing = (m_state == M_SNZ);
            if (!m_en) m_state = M_IDLE;
            else if (m_state == M_IDLE) begin
                if (trig) begin m_state = M_RING; m_start = m_edge; end
            end else if (m_state == M_RING) begin
                if (stop_ev) m_state = M_IDLE;
                else if (snz_ev) begin m_state = M_SNZ; m_left = SNOOZE_MIN; end
                else if (m_edge - m_start == RING_CYCLES) m_state = M_IDLE;
            end else begin
                if (stop_ev) m_state = M_IDLE;
                else if (tick_ev) begin
                    if (m_left == 1) begin m_state = M_RING; m_start = m_edge; end
                    else m_left--;
                end
            end
            if (!w_en_n) begin
                if (addr[3:0] == 4'b1010 && t <= 8'd23) m_ah = int'(t);
                if (addr[3:0] == 4'b1011 && t <= 8'd59) m_am = int'(t);
                if (addr[3:0] == 4'b1100) m_en = t[0];
            end
            m_match_q = match;
            m_prev    = int'(minute);
            m_stop_q  = stop_n;
            m_snz_q   = snooze_n;
            m_beep    = (m_state == M_RING) && (((m_edge - m_start) / BEEP_HALF) % 2 == 0);
            m_edge++;
        end
    end

    always @(negedge clock) begin
        check("model_beep", beep, m_beep);
        check("model_ringing", ringing, m_ringing);
        check("model_snoozing", snoozing, m_snoozing);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clock);
        #2;
    endtask

    task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
        addr = {12'h5A3, a};
        t = d;
        w_en_n = 1'b0;
        tick(1);
        w_en_n = 1'b1;
    endtask

    task automatic stop_pulse();
        stop_n = 1'b0;
        tick(1);
        stop_n = 1'b1;
        tick(3);
    endtask

    task automatic wait_ring(input string name);
        int n = 0;
        while (ringing !== 1'b1 && n < 20) begin
            tick(1);
            n++;
        end
        check(name, ringing, 1'b1);
    endtask

    task automatic arm_ring(input string name);
        minute = 6'd29;
        tick(2);
        minute = 6'd30;
        wait_ring(name);
    endtask

    typedef struct {
        logic [3:0] a;
        logic [7:0] d;
        logic [5:0] h;
        logic [5:0] m;
        logic       exp_ring;
    } vec_t;

    initial begin
        vec_t vecs [10];
        int   cnt;
        int   guard;

        vecs[0] = '{4'hA, 8'd7,    6'd6,  6'd0,  1'b0};
        vecs[1] = '{4'hB, 8'd30,   6'd7,  6'd30, 1'b0};
        vecs[2] = '{4'hC, 8'd1,    6'd7,  6'd29, 1'b0};
        vecs[3] = '{4'hB, 8'd60,   6'd7,  6'd29, 1'b0};
        vecs[4] = '{4'hA, 8'd24,   6'd7,  6'd29, 1'b0};
        vecs[5] = '{4'h8, 8'h55,   6'd7,  6'd30, 1'b1};
        vecs[6] = '{4'hA, 8'd23,   6'd7,  6'd30, 1'b0};
        vecs[7] = '{4'hB, 8'd59,   6'd23, 6'd59, 1'b1};
        vecs[8] = '{4'hC, 8'd0,    6'd23, 6'd59, 1'b0};
        vecs[9] = '{4'hC, 8'd1,    6'd23, 6'd59, 1'b1};

        repeat (2) @(posedge clock);
        #2;
        check("reset_beep", beep, 1'b0);
        check("reset_ringing", ringing, 1'b0);
        check("reset_snoozing", snoozing, 1'b0);
        rst_n = 1'b1;
        tick(2);

        for (int i = 0; i < 10; i++) begin
            hour = vecs[i].h;
            minute = vecs[i].m;
            cpu_write(vecs[i].a, vecs[i].d);
            tick(3);
            check($sformatf("vec%0d_ringing", i), ringing, vecs[i].exp_ring);
            if (vecs[i].exp_ring) begin
                stop_pulse();
                check($sformatf("vec%0d_stopped", i), ringing, 1'b0);
            end
        end

        // Two-clock latency, beep phase and exact timeout with the minute held.
        cpu_write(4'hA, 8'd7);
        cpu_write(4'hB, 8'd30);
        hour = 6'd7;
        minute = 6'd29;
        tick(2);
        minute = 6'd30;
        @(negedge clock);
        check("lat_edge0", ringing, 1'b0);
        @(negedge clock);
        check("lat_edge1", ringing, 1'b0);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("beep_phase%0d", k), beep, ((k / BEEP_HALF) % 2) == 0);
            if (k == 1) check("lat_edge2", ringing, 1'b1);
            if (ringing === 1'b1) cnt++;
            @(negedge clock);
        end
        guard = 0;
        while (ringing === 1'b1 && guard < 300) begin
            cnt++;
            guard++;
            @(negedge clock);
        end
        check_int("ring_length", cnt, RING_CYCLES);
        tick(10);
        check("no_retrigger", ringing, 1'b0);

        // Rejected writes while ringing, then disable.
        arm_ring("dis_ring");
        cpu_write(4'hA, 8'd24);
        cpu_write(4'hB, 8'd60);
        check("bad_wr_still_ring", ringing, 1'b1);
        cpu_write(4'hC, 8'd0);
        tick(1);
        check("dis_beep", beep, 1'b0);
        tick(1);
        check("dis_ringing", ringing, 1'b0);
        minute = 6'd0;
        cpu_write(4'hC, 8'd1);
        tick(2);

        // Stop and snooze together: stop wins.
        arm_ring("both_ring");
        stop_n = 1'b0;
        snooze_n = 1'b0;
        tick(1);
        stop_n = 1'b1;
        snooze_n = 1'b1;
        tick(3);
        check("both_ringing", ringing, 1'b0);
        check("both_snoozing", snoozing, 1'b0);
        tick(5);
        check("both_snoozing_late", snoozing, 1'b0);

        // Stop held low across the trigger: only its falling edge counts.
        minute = 6'd29;
        stop_n = 1'b0;
        tick(2);
        minute = 6'd30;
        tick(4);
        check("held_stop_rings", ringing, 1'b1);
        tick(4);
        stop_n = 1'b1;
        tick(2);
        check("held_stop_release", ringing, 1'b1);
        stop_pulse();
        check("held_stop_pulse", ringing, 1'b0);

        // Snooze.
        arm_ring("snz_ring");
        snooze_n = 1'b0;
        tick(1);
        snooze_n = 1'b1;
        tick(3);
`ifdef ALARM_SNOOZE_EN
        check("snz_snoozing", snoozing, 1'b1);
        check("snz_ringing", ringing, 1'b0);
        minute = 6'd31;
        tick(3);
        check("snz_min31", snoozing, 1'b1);
        minute = 6'd32;
        tick(3);
        check("snz_min32_ring", ringing, 1'b1);
        check("snz_min32_snz", snoozing, 1'b0);
`else
        check("snz_ignored_ring", ringing, 1'b1);
        check("snz_ignored_snz", snoozing, 1'b0);
`endif
        stop_pulse();
        check("snz_stopped", ringing, 1'b0);

        // Asynchronous reset mid-ring clears the alarm enable too.
        hour = 6'd7;
        arm_ring("rst_ring");
        check("rst_pre_beep", beep, 1'b1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_async_beep", beep, 1'b0);
        check("rst_async_ringing", ringing, 1'b0);
        tick(2);
        rst_n = 1'b1;
        minute = 6'd29;
        tick(2);
        minute = 6'd30;
        tick(5);
        check("post_rst_no_ring", ringing, 1'b0);

        // Randomized traffic, checked cycle by cycle against the model.
        cpu_write(4'hA, 8'd7);
        cpu_write(4'hB, 8'd30);
        cpu_write(4'hC, 8'd1);
        for (int c = 0; c < 3000; c++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                case ($urandom_range(0, 5))
                    0: begin addr[3:0] = 4'hA; t = ($urandom_range(0, 1) != 0) ? 8'd7 : 8'($urandom_range(0, 30)); end
                    1: begin addr[3:0] = 4'hB; t = ($urandom_range(0, 1) != 0) ? 8'd30 : 8'($urandom_range(0, 70)); end
                    2: begin addr[3:0] = 4'hC; t = {7'($urandom), ($urandom_range(0, 3) != 0)}; end
                    3: begin addr[3:0] = 4'h8; t = 8'($urandom); end
                    4: begin addr[3:0] = 4'h9; t = 8'($urandom); end
                    default: begin addr[3:0] = 4'($urandom); t = 8'($urandom); end
                endcase
                addr[15:4] = 12'($urandom);
                w_en_n = 1'b0;
            end else begin
                w_en_n = 1'b1;
            end
            if ($urandom_range(0, 49) == 0) minute = 6'($urandom_range(29, 32));
            if ($urandom_range(0, 299) == 0) minute = 6'($urandom_range(0, 59));
            if ($urandom_range(0, 99) == 0) hour = ($urandom_range(0, 1) != 0) ? 6'd7 : 6'($urandom_range(0, 23));
            stop_n   = ($urandom_range(0, 99) >= 3);
            snooze_n = ($urandom_range(0, 99) >= 3);
            tick(1);
        end
        w_en_n = 1'b1;
        stop_n = 1'b1;
        snooze_n = 1'b1;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
